// File: rtl/des_pkg.sv
// Shared DES tables, key-rotation helpers and FSM encoding for the round sequencer.
// The right-rotate schedule is only built when DES_DECRYPT_EN is defined.
package des_pkg;

    localparam int ROUNDS = 16;
    localparam int HALF   = 28;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [6:0] IP_T [1:64] = '{
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
        7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
        7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
        7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
    };

    localparam logic [6:0] PC1_T [1:56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    localparam logic [5:0] PC2_T [1:48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Indexed by round number minus one.
    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

`ifdef DES_DECRYPT_EN
    localparam logic [1:0] RSHIFT [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [1:HALF] ror28(input logic [1:HALF] x, input logic [1:0] s);
        logic [1:HALF] y;
        case (s)
            2'd1:    y = {x[28], x[1:27]};
            2'd2:    y = {x[27:28], x[1:26]};
            default: y = x;
        endcase
        return y;
    endfunction
`endif

    function automatic logic [1:HALF] rol28(input logic [1:HALF] x, input logic [1:0] s);
        logic [1:HALF] y;
        case (s)
            2'd1:    y = {x[2:28], x[1]};
            2'd2:    y = {x[3:28], x[1:2]};
            default: y = x;
        endcase
        return y;
    endfunction

    function automatic logic [1:64] ip(input logic [1:64] x);
        logic [1:64] y;
        y = '0;
        for (int i = 1; i <= 64; i++) y[i] = x[IP_T[i]];
        return y;
    endfunction

    // FP is the inverse of IP, so it scatters through the same table.
    function automatic logic [1:64] fp(input logic [1:64] x);
        logic [1:64] y;
        y = '0;
        for (int i = 1; i <= 64; i++) y[IP_T[i]] = x[i];
        return y;
    endfunction

    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] y;
        y = '0;
        for (int i = 1; i <= 56; i++) y[i] = k[PC1_T[i]];
        return y;
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] cd);
        logic [1:48] y;
        y = '0;
        for (int i = 1; i <= 48; i++) y[i] = cd[PC2_T[i]];
        return y;
    endfunction

endpackage

// File: rtl/des_key_sched.sv
// DES key schedule: holds the C/D halves and produces the subkey for the current round.
// Right-rotation for decryption exists only when DES_DECRYPT_EN is defined.
module des_key_sched
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        active,
    input  logic [1:64] key,
    input  logic        dec,
    input  logic [3:0]  rnd_idx,
    output logic [1:48] rnd_key
);

    logic [1:56] cd_r;
    logic [1:56] cd_next_s;

`ifdef DES_DECRYPT_EN
    // Decryption walks the schedule backwards; round 1 reuses the unrotated halves.
    always_comb begin
        if (dec) begin
            cd_next_s = {ror28(cd_r[1:28], RSHIFT[rnd_idx]), ror28(cd_r[29:56], RSHIFT[rnd_idx])};
        end else begin
            cd_next_s = {rol28(cd_r[1:28], SHIFT[rnd_idx]), rol28(cd_r[29:56], SHIFT[rnd_idx])};
        end
    end
`else
    logic unused_dec_s;
    assign unused_dec_s = dec;

    // Encrypt-only schedule.
    always_comb begin
        cd_next_s = {rol28(cd_r[1:28], SHIFT[rnd_idx]), rol28(cd_r[29:56], SHIFT[rnd_idx])};
    end
`endif

    // C/D register: loaded from PC-1 on accept, advanced once per round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cd_r <= '0;
        end else if (load) begin
            cd_r <= pc1(key);
        end else if (active) begin
            cd_r <= cd_next_s;
        end else begin
            cd_r <= cd_r;
        end
    end

    // Subkey follows the rotated halves during rounds, the held halves otherwise.
    always_comb begin
        if (active) begin
            rnd_key = pc2(cd_next_s);
        end else begin
            rnd_key = pc2(cd_r);
        end
    end

endmodule

// File: rtl/des_round_sequencer.sv
// Iterative DES controller: IP/FP, L/R state, round counter and handshakes around an
// external single-round datapath. Decryption is enabled by defining DES_DECRYPT_EN.
module des_round_sequencer
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:64] in_data,
    input  logic [1:64] in_key,
    input  logic        in_dec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:64] out_data,
    output logic        busy,
    output logic [1:64] rnd_in,
    output logic [1:48] rnd_key,
    input  logic [1:64] rnd_out
);

    state_e      state_r;
    state_e      state_next_s;
    logic [1:64] lr_r;
    logic [4:0]  rnd_cnt_r;
    logic        dec_q_r;
    logic        dec_s;
    logic [1:64] out_data_r;
    logic        out_valid_r;
    logic        accept_s;
    logic        round_s;
    logic        last_s;
    logic        release_s;
    logic [3:0]  rnd_idx_s;

`ifdef DES_DECRYPT_EN
    assign dec_s = in_dec;
`else
    logic unused_dec_s;
    assign unused_dec_s = in_dec;
    assign dec_s        = 1'b0;
`endif

    assign accept_s  = (state_r == ST_IDLE) && in_valid;
    assign round_s   = (state_r == ST_ROUND);
    assign last_s    = round_s && (rnd_cnt_r == 5'(ROUNDS));
    assign release_s = (state_r == ST_DONE) && out_ready;
    assign rnd_idx_s = rnd_cnt_r[3:0] - 4'd1;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_next_s = ST_ROUND;
                else          state_next_s = ST_IDLE;
            end
            ST_ROUND: begin
                if (rnd_cnt_r == 5'(ROUNDS)) state_next_s = ST_DONE;
                else                         state_next_s = ST_ROUND;
            end
            ST_DONE: begin
                if (out_ready) state_next_s = ST_IDLE;
                else           state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // L/R state, round counter and direction latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lr_r      <= '0;
            rnd_cnt_r <= 5'd0;
            dec_q_r   <= 1'b0;
        end else if (accept_s) begin
            lr_r      <= ip(in_data);
            rnd_cnt_r <= 5'd1;
            dec_q_r   <= dec_s;
        end else if (last_s) begin
            lr_r      <= rnd_out;
            rnd_cnt_r <= 5'd0;
            dec_q_r   <= dec_q_r;
        end else if (round_s) begin
            lr_r      <= rnd_out;
            rnd_cnt_r <= rnd_cnt_r + 5'd1;
            dec_q_r   <= dec_q_r;
        end else begin
            lr_r      <= lr_r;
            rnd_cnt_r <= rnd_cnt_r;
            dec_q_r   <= dec_q_r;
        end
    end

    // Result register: the last round's halves are swapped back before FP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else if (last_s) begin
            out_data_r  <= fp({rnd_out[33:64], rnd_out[1:32]});
            out_valid_r <= 1'b1;
        end else if (release_s) begin
            out_data_r  <= out_data_r;
            out_valid_r <= 1'b0;
        end else begin
            out_data_r  <= out_data_r;
            out_valid_r <= out_valid_r;
        end
    end

    des_key_sched u_key_sched (
        .clk     (clk),
        .rst     (rst),
        .load    (accept_s),
        .active  (round_s),
        .key     (in_key),
        .dec     (dec_q_r),
        .rnd_idx (rnd_idx_s),
        .rnd_key (rnd_key)
    );

    assign in_ready  = (state_r == ST_IDLE);
    assign busy      = (state_r == ST_ROUND) || (state_r == ST_DONE);
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign rnd_in    = lr_r;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench for des_round_sequencer with a behavioural DES round on the rnd_* ports.
// Decrypt vectors run only when DES_DECRYPT_EN is defined.
module tb_des_round_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:64] in_data;
    logic [1:64] in_key;
    logic        in_dec;
    logic        out_valid;
    logic        out_ready;
    logic [1:64] out_data;
    logic        busy;
    logic [1:64] rnd_in;
    logic [1:48] rnd_key;
    logic [1:64] rnd_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    des_round_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_dec    (in_dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .rnd_in    (rnd_in),
        .rnd_key   (rnd_key),
        .rnd_out   (rnd_out)
    );

    int e_t [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                     12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                     24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    int p_t [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                     2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    logic [255:0] s_t [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [1:32] f_fn(input logic [1:32] r, input logic [1:48] k);
        logic [1:48]  x;
        logic [1:32]  s;
        logic [1:32]  y;
        logic [5:0]   b;
        logic [255:0] tbl;
        int           idx;
        for (int i = 1; i <= 48; i++) x[i] = r[e_t[i-1]] ^ k[i];
        for (int n = 0; n < 8; n++) begin
            b   = x[6*n+1 +: 6];
            idx = {b[5], b[0]} * 16 + b[4:1];
            tbl = s_t[n];
            s[4*n+1 +: 4] = tbl[255 - 4*idx -: 4];
        end
        for (int i = 1; i <= 32; i++) y[i] = s[p_t[i-1]];
        return y;
    endfunction

    // Stand-in for the shared single-round datapath.
    always_comb begin
        rnd_out = {rnd_in[33:64], rnd_in[1:32] ^ f_fn(rnd_in[33:64], rnd_key)};
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic send_block(input logic [1:64] data, input logic [1:64] key, input logic dec,
                              output logic [1:48] key1, output logic [1:64] lr0,
                              output int lat, output logic [1:64] res);
        int w;
        w        = 0;
        in_data  = data;
        in_key   = key;
        in_dec   = dec;
        in_valid = 1'b1;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~data;
        in_key   = ~key;
        in_dec   = 1'b0;
        key1     = rnd_key;
        lr0      = rnd_in;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_data;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [1:48] k1;
    logic [1:64] lr0;
    logic [1:64] res;
    int          lat;
    logic [63:0] b2b_key  [4] = '{64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF,
                                  64'h3000000000000000, 64'h1111111111111111};
    logic [63:0] b2b_data [4] = '{64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF,
                                  64'h1000000000000001, 64'h1111111111111111};
    logic [63:0] b2b_exp  [4] = '{64'h8CA64DE9C1B123A7, 64'h7359B2163E4EDC58,
                                  64'h958E6E627A05557B, 64'hF40379AB9E0EC533};
    int          acc_cyc  [4];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        in_dec    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_out_data", out_data, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Classic worked example, including first subkey and IP output.
        send_block(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, k1, lr0, lat, res);
        check_eq("v1_k1", 64'(k1), 64'h1B02EFFC7072);
        check_eq("v1_ip", lr0, 64'hCC00CCFFF0AAF0AA);
        check_eq("v1_latency", 64'(lat), 64'd16);
        check_eq("v1_result", res, 64'h85E813540F0AB405);
        check_eq("v1_busy_done", 64'(busy), 64'd1);
        drain();
        check_eq("v1_released", 64'(out_valid), 64'd0);
        check_eq("v1_idle_ready", 64'(in_ready), 64'd1);

        send_block(64'h8787878787878787, 64'h0E329232EA6D0D73, 1'b0, k1, lr0, lat, res);
        check_eq("v2_result", res, 64'h0000000000000000);
        drain();

`ifdef DES_DECRYPT_EN
        send_block(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1, k1, lr0, lat, res);
        check_eq("dec_k1_is_k16", 64'(k1), 64'hCB3D8B0E17F5);
        check_eq("dec_latency", 64'(lat), 64'd16);
        check_eq("dec_result", res, 64'h0123456789ABCDEF);
        drain();
`endif

        // Backpressure: result held while a second block waits.
        send_block(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, k1, lr0, lat, res);
        in_data  = 64'h8787878787878787;
        in_key   = 64'h0E329232EA6D0D73;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("bp_hold_data", out_data, 64'h85E813540F0AB405);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        end
        check_eq("bp_valid_held", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("bp_release_busy", 64'(busy), 64'd0);
        check_eq("bp_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("bp_second_accept", 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("bp_second_latency", 64'(lat), 64'd16);
        check_eq("bp_second_result", out_data, 64'h0000000000000000);
        drain();

        // Reset in the middle of round 8.
        in_data  = 64'h0123456789ABCDEF;
        in_key   = 64'h133457799BBCDFF1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_out_data", out_data, 64'd0);
        check_eq("mid_rst_lr", rnd_in, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_block(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, k1, lr0, lat, res);
        check_eq("post_rst_result", res, 64'h85E813540F0AB405);
        drain();

        // Back-to-back blocks with the consumer always ready.
        begin
            int  cyc;
            int  got;
            int  idx;
            logic acc;
            cyc       = 0;
            got       = 0;
            idx       = 0;
            out_ready = 1'b1;
            in_data   = b2b_data[0];
            in_key    = b2b_key[0];
            in_valid  = 1'b1;
            while (got < 4 && cyc < 200) begin
                acc = in_valid && in_ready;
                @(posedge clk); #1;
                cyc++;
                if (acc) begin
                    acc_cyc[idx] = cyc;
                    idx++;
                    if (idx < 4) begin
                        in_data = b2b_data[idx];
                        in_key  = b2b_key[idx];
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                if (out_valid) begin
                    check_eq($sformatf("b2b_result%0d", got), out_data, b2b_exp[got]);
                    got++;
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            check_eq("b2b_count", 64'(got), 64'd4);
            for (int i = 1; i < 4; i++) begin
                if (i < idx) check_eq($sformatf("b2b_period%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd18);
                else         check_eq($sformatf("b2b_accept%0d", i), 64'(idx), 64'd4);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/des_round_sequencer.md
# des_round_sequencer

Iterative DES controller that runs one 64-bit block through 16 rounds on a single shared, combinational single-round datapath, one round per clock. It owns the initial/final permutations, the L/R state register, the C/D key-schedule registers, the round counter and a valid/ready handshake on both sides. It sits between the block-level host interface and the round datapath, which it drives through the `rnd_*` ports.

## Interface
Parameters: none (all tables fixed by the DES standard).

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  block + key offered
- `in_ready`  out  1  sequencer can accept (high only in IDLE)
- `in_data`  in  [1:64]  plaintext/ciphertext; bit 1 = MSB
- `in_key`  in  [1:64]  DES key incl. parity bits 8,16..64 (ignored)
- `in_dec`  in  1  1 = decrypt (only with `DES_DECRYPT_EN`)
- `out_valid`  out  1  result held valid
- `out_ready`  in  1  consumer accepts result
- `out_data`  out  [1:64]  result after FP
- `busy`  out  1  high in ROUND or DONE
- `rnd_in`  out  [1:64]  {L,R} to round datapath
- `rnd_key`  out  [1:48]  subkey Ki for current round
- `rnd_out`  in  [1:64]  {R, L xor f(R,Ki)} from round datapath, same cycle

## Operation
- FSM: IDLE -> ROUND -> DONE -> IDLE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`: `lr` <= IP(`in_data`); `cd` <= PC-1(`in_key`); `dec_q` <= `in_dec`; `rnd_cnt` <= 1; go ROUND.
- ROUND (`rnd_cnt` 1..16): `rnd_in` = `lr`. `cd_next` = encrypt: each 28-bit half rotated left by SHIFT[rnd_cnt] (1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1); decrypt: rotated right by RSHIFT[rnd_cnt] (0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1). `rnd_key` = PC-2(`cd_next`). Each cycle: `lr` <= `rnd_out`, `cd` <= `cd_next`, `rnd_cnt` += 1.
- At round 16 edge: `out_data` <= FP({`rnd_out`[33:64], `rnd_out`[1:32]}) (final half-swap); `out_valid` <= 1; go DONE.
- DONE: hold `out_data`, `out_valid`. On `out_ready`: `out_valid` <= 0, go IDLE. `in_valid` ignored in DONE.
- Outside ROUND, `rnd_in`/`rnd_key` are don't-care but must not be X (drive `lr` and PC-2(`cd`)).
- Total C/D rotation is 28 per block, so `cd` returns to PC-1 value after round 16 (assertion target).

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0, `lr`=0, `cd`=0, `rnd_cnt`=0, `dec_q`=0.
- Accept at edge T0; rounds occupy edges T1..T16; `out_valid` rises after T16 (16 cycles after acceptance edge).
- Minimum block period 18 cycles (accept, 16 rounds, DONE with `out_ready` already high).
- `in_ready` is combinational from state only; no input->output combinational path except `rnd_out`->`lr`/`out_data`.
- `in_data`/`in_key` sampled only at acceptance; may change afterwards.
- `rst` asserted mid-ROUND or in DONE: immediate return to reset values; partial result discarded, `out_valid` never glitches high.
- `out_ready` high while not in DONE: no effect.

## Configuration
- `DES_DECRYPT_EN` defined: `in_dec` honoured, RSHIFT schedule and right-rotate logic present.
- Undefined: `in_dec` ignored, `dec_q` tied 0, encrypt only; port list unchanged.

## Structure
- Package `des_pkg`: IP, FP, PC-1, PC-2 tables as functions; SHIFT and RSHIFT arrays; FSM state enum; constants ROUNDS=16, HALF=28.
- One sub-module `des_key_sched`: holds `cd`, computes `cd_next` and `rnd_key` from `rnd_cnt`, `dec_q`, load strobe.
- Round datapath stays external; bench binds the team's existing round module to `rnd_*`.

## Test plan
- Encrypt key 133457799BBCDFF1, data 0123456789ABCDEF -> `out_data` 85E813540F0AB405, `out_valid` 16 cycles after accept.
- Encrypt key 0E329232EA6D0D73, data 8787878787878787 -> 0000000000000000.
- Decrypt (`DES_DECRYPT_EN`) key 133457799BBCDFF1, data 85E813540F0AB405 -> 0123456789ABCDEF; round-1 `rnd_key` equals encrypt round-16 key.
- Backpressure: `out_ready` low 10 cycles after result -> `out_data` stable, `in_ready`=0 throughout, second `in_valid` not accepted until one cycle after `out_ready`.
- `rst` pulsed at round 8 -> all outputs at reset values next cycle; following encrypt of vector 1 still yields 85E813540F0AB405.
- Back-to-back 4 random blocks vs. software model, `out_ready` tied 1 -> accept period exactly 18 cycles, all results match.
